fuzzification_scheduler: RTL
============================

# fuzzification_scheduler

Shares one fuzzification engine (two 10-bit crisp inputs in, one-bit result out, `start` / `outResultValid` contract) among several requesters. It arbitrates round-robin, latches the granted input pair, and pulses `start`. It then waits for the engine result under a timeout and returns the result, or a timeout flag, to the granted requester. It sits between the input-sampling front end and the fuzzification engine.

## Interface
**Parameters**
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 10: width of each crisp input.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort, ≥ 2.

**Ports**
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `io_reqValid` in NUM_REQ: per-requester request.
- `io_reqReady` out NUM_REQ: one-hot grant, acceptance handshake.
- `io_reqInput_0` in NUM_REQ*DATA_W: packed first inputs; requester i is at bits [i*DATA_W +: DATA_W].
- `io_reqInput_1` in NUM_REQ*DATA_W: packed second inputs, same packing.
- `io_respValid` out NUM_REQ: one-hot, one-cycle response pulse.
- `io_respResult` out 1: engine result. Valid while any `io_respValid` bit is high.
- `io_respTimeout` out 1: high with `io_respValid` when the engine timed out.
- `io_engStart` out 1: one-cycle start pulse to the engine.
- `io_engInput_0` out DATA_W: latched first input, held stable from ISSUE through RESP.
- `io_engInput_1` out DATA_W: latched second input, held stable from ISSUE through RESP.
- `io_engResultValid` in 1: engine result strobe.
- `io_engResult` in 1: engine result bit.
- `io_busy` out 1: high in every state except IDLE.
- `io_strayCount` out 8: saturating count of `io_engResultValid` pulses that arrive outside WAIT.

## Operation
**States:** IDLE → ISSUE → WAIT → RESP → IDLE.

**IDLE**
- If any `io_reqValid` bit is set, the round-robin arbiter selects the first valid index at or after `rrPtr`, wrapping modulo NUM_REQ.
- `io_reqReady[g]` is asserted combinationally for the selected index only.
- On the handshake (valid & ready):
  - latch `g` and both inputs of `g`;
  - set `rrPtr` = (g+1) mod NUM_REQ;
  - go to ISSUE.
- With no valid request, stay in IDLE. `io_reqReady` is all-zero.

**ISSUE**
- Drive `io_engStart`=1 for exactly this cycle, with the latched inputs on `io_engInput_*`.
- Clear `timeoutCnt` and go to WAIT.

**WAIT**
- When `io_engResultValid`=1: capture `io_engResult`, clear the timeout flag, go to RESP.
- Otherwise, if `timeoutCnt` == TIMEOUT-1: set result=0 and the timeout flag, go to RESP.
- Otherwise increment `timeoutCnt`.
- If `io_engResultValid` arrives in the same cycle the counter expires, the result wins and the timeout flag stays 0.

**RESP**
- Assert `io_respValid[g]`=1, with `io_respResult` and `io_respTimeout` driven from the captured values.
- Go to IDLE. There is no back-pressure on responses.

**Other rules**
- `io_reqReady` is 0 in every state except IDLE, so a single requester needs at least 4 cycles per transaction.
- A stray `io_engResultValid` (seen in IDLE, ISSUE or RESP) is ignored. It increments `io_strayCount`, which saturates at 255.
- Requests held across other requesters' grants are not lost. Fairness: a continuously valid requester waits at most NUM_REQ-1 transactions.

## Timing
**Reset values:** state=IDLE, `rrPtr`=0, `timeoutCnt`=0, latched inputs=0, captured result=0, timeout flag=0, `io_strayCount`=0. Every output is 0 during and after reset until the first handshake.

**Reset mid-transaction:** asserting `reset` in any state aborts immediately. No response is issued and the engine is not notified.

**Latency:** from the handshake in cycle c:
- `io_engStart` in c+1;
- the earliest `io_engResultValid` is sampled in c+2;
- `io_respValid` in c+3.
In general, a result sampled in cycle k produces the response in k+1. A timeout produces the response in c+2+TIMEOUT.

**Widths:**
- `timeoutCnt` is $clog2(TIMEOUT) bits.
- `rrPtr` and `g` are $clog2(NUM_REQ) bits, minimum 1.
- No arithmetic on the data; the inputs pass through unchanged.

## Structure
**Package `fuzzy_sched_pkg`**
- State enum: IDLE, ISSUE, WAIT, RESP.
- Default constants: DATA_W=10, STRAY_W=8.

**Sub-module `rr_arbiter`**
- Parameterised on NUM_REQ.
- Inputs: request vector, pointer. Outputs: one-hot grant, binary index, any-valid.
- Purely combinational. The pointer register stays in the scheduler.

## Test plan
- Single request: req0 with (5,12), engine returns result=1 after 3 cycles → `io_engStart` in c+1 with inputs 5/12, `io_respValid`=0001, result=1, timeout=0 in c+5.
- Contention: all four requesters valid continuously → grants in order 0,1,2,3,0, each `io_respValid` one-hot and matching its grant.
- Pointer wrap: after a grant to requester 3, requesters 0 and 2 both valid → requester 0 is granted next.
- Timeout: TIMEOUT=8, engine never responds → `io_respValid` in c+10 with timeout=1 and result=0. A result arriving on the expiry cycle instead gives timeout=0.
- Stray strobes: pulse `io_engResultValid` in IDLE 300 times → `io_strayCount` saturates at 255 and no response is issued.
- Reset in WAIT: assert `reset` two cycles after start → all outputs 0 at once, and the next request is handled from requester 0 with normal latency.

Source files
------------

// File: rtl/fuzzy_sched_pkg.sv
// Shared types and defaults for the fuzzification scheduler.
// Holds the scheduler state encoding and default widths.
package fuzzy_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 10;
    localparam int STRAY_W    = 8;

endpackage

// File: rtl/fuzzification_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or
// after ptr_i (wrapping). Ports: req_i, ptr_i -> grant_o, idx_o, any_o.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        // Scan farthest-first so the nearest valid index overwrites last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fuzzification_scheduler.sv
// Shares one fuzzification engine among NUM_REQ requesters: round-robin
// grant, latch inputs, pulse start, wait with timeout, return response.
// Ports: io_req* (requests), io_resp* (responses), io_eng* (engine),
// io_busy (not IDLE), io_strayCount (result strobes seen outside WAIT).
module fuzzification_scheduler
    import fuzzy_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        io_reqValid,
    output logic [NUM_REQ-1:0]        io_reqReady,
    input  logic [NUM_REQ*DATA_W-1:0] io_reqInput_0,
    input  logic [NUM_REQ*DATA_W-1:0] io_reqInput_1,
    output logic [NUM_REQ-1:0]        io_respValid,
    output logic                      io_respResult,
    output logic                      io_respTimeout,
    output logic                      io_engStart,
    output logic [DATA_W-1:0]         io_engInput_0,
    output logic [DATA_W-1:0]         io_engInput_1,
    input  logic                      io_engResultValid,
    input  logic                      io_engResult,
    output logic                      io_busy,
    output logic [STRAY_W-1:0]        io_strayCount
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]      T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_REQ - 1);
    localparam logic [STRAY_W-1:0] STRAY_MAX = '1;

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       g_q, g_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [DATA_W-1:0]   in0_q, in0_d;
    logic [DATA_W-1:0]   in1_q, in1_d;
    logic                res_q, res_d;
    logic                to_q, to_d;
    logic [STRAY_W-1:0]  stray_q, stray_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (io_reqValid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        g_d      = g_q;
        tcnt_d   = tcnt_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        res_d    = res_q;
        to_d     = to_q;
        stray_d  = stray_q;

        unique case (state_q)
            IDLE: begin
                // Ready mirrors the grant, so any valid request handshakes.
                if (arb_any) begin
                    g_d      = arb_idx;
                    in0_d    = io_reqInput_0[arb_idx*DATA_W +: DATA_W];
                    in1_d    = io_reqInput_1[arb_idx*DATA_W +: DATA_W];
                    rr_ptr_d = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result on the expiry cycle takes priority over timeout.
                if (io_engResultValid) begin
                    res_d   = io_engResult;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == T_LAST) begin
                    res_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        if (io_engResultValid && state_q != WAIT && stray_q != STRAY_MAX) begin
            stray_d = stray_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            g_q      <= '0;
            tcnt_q   <= '0;
            in0_q    <= '0;
            in1_q    <= '0;
            res_q    <= 1'b0;
            to_q     <= 1'b0;
            stray_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_q      <= g_d;
            tcnt_q   <= tcnt_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            res_q    <= res_d;
            to_q     <= to_d;
            stray_q  <= stray_d;
        end
    end

    assign io_reqReady    = (state_q == IDLE) ? arb_grant : '0;
    assign io_engStart    = (state_q == ISSUE);
    assign io_engInput_0  = in0_q;
    assign io_engInput_1  = in1_q;
    assign io_respValid   = (state_q == RESP) ? (NUM_REQ'(1) << g_q) : '0;
    assign io_respResult  = (state_q == RESP) & res_q;
    assign io_respTimeout = (state_q == RESP) & to_q;
    assign io_busy        = (state_q != IDLE);
    assign io_strayCount  = stray_q;

endmodule
